// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types used by decode, write-back and
// the register file itself.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_word.sv
// One architectural register: write-enabled word with asynchronous
// active-low clear.
module reg_word #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] data_q
);

    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            data_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule : reg_word

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with write-through
// bypass, one write port, and a per-register pending-write scoreboard.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = reg_file_pkg::DATA_W,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_b,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [NUM_REGS-1:0] wr_sel;
    logic [DATA_W-1:0]   word_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                hit_a;
    logic                hit_b;

    // r0 has no storage: slot 0 is a hard zero and never selected.
    assign wr_sel[0] = 1'b0;
    assign word_q[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_word
            assign wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));

            reg_word #(.W(DATA_W)) u_word (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr_sel[gi]),
                .wr_data (wr_data),
                .data_q  (word_q[gi])
            );
        end
    endgenerate

    // Clear first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hit_a = wr_en && (wr_addr == rd_addr_a);
    assign hit_b = wr_en && (wr_addr == rd_addr_b);

    // Bypass is gated by reset so nothing leaks through while it is held.
    assign rd_data_a = (!reset || rd_addr_a == '0) ? '0
                     : hit_a ? wr_data : word_q[rd_addr_a];
    assign rd_data_b = (!reset || rd_addr_b == '0) ? '0
                     : hit_b ? wr_data : word_q[rd_addr_b];

    assign rd_busy_a = reset && busy_q[rd_addr_a] && !hit_a;
    assign rd_busy_b = reset && busy_q[rd_addr_b] && !hit_b;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: expectations are queued as stimulus is
// driven and popped when the read ports are sampled.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic        rd_busy_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        rd_busy_b;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    typedef struct {
        string       name;
        bit          port_b;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    logic [32:0] obs;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] shadow [32];

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_busy_a  (rd_busy_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_busy_b  (rd_busy_b),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic expect_port(input string name, input bit port_b,
                               input logic [31:0] data, input logic busy);
        exp_t x;
        x.name = name; x.port_b = port_b; x.data = data; x.busy = busy;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b0; idle();
        rd_addr_a = 5'd5; rd_addr_b = 5'd0; issue_addr = 5'd0;
        wr_addr = 5'd5; wr_data = 32'hCAFE_F00D; wr_en = 1'b1;
        expect_port("reset_bypass_gated", 1'b0, 32'h0, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        step(); step();
        reset = 1'b1;
        wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; wr_en = 1'b1;
        step();
        idle(); issue_en = 1'b1; issue_addr = 5'd5;
        step();
        idle();
        expect_port("reset_pre_data", 1'b0, 32'hDEAD_BEEF, 1'b1);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        // Mid-cycle asynchronous reset with a write and issue pending.
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1;
        issue_en = 1'b1; issue_addr = 5'd5;
        #1 reset = 1'b0;
        #1;
        expect_port("reset_async_data", 1'b0, 32'h0, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        step();
        idle(); reset = 1'b1;
        step();
        rd_addr_b = 5'd6;
        expect_port("reset_after_release_5", 1'b0, 32'h0, 1'b0);
        expect_port("reset_after_release_6", 1'b1, 32'h0, 1'b0);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    endtask

    task automatic test_bypass();
        idle();
        rd_addr_a = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234_5678;
        expect_port("bypass_same_cycle", 1'b0, 32'h1234_5678, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        step();
        idle(); shadow[3] = 32'h1234_5678;
        expect_port("bypass_stored", 1'b0, 32'h1234_5678, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
    endtask

    task automatic test_r0();
        rd_addr_b = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        for (int c = 0; c < 3; c++) begin
            expect_port($sformatf("r0_cycle%0d", c), 1'b1, 32'h0, 1'b0);
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front(); tests_run++;
                obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
                if (obs !== {e.busy, e.data}) begin
                    tests_failed++;
                    $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                             e.name, obs[32], obs[31:0], e.busy, e.data);
                end
            end
            step();
            if (c == 1) idle();
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_addr_a = 5'd7;
        issue_en = 1'b1; issue_addr = 5'd7;
        expect_port("sb_issue_cycle", 1'b0, 32'h0, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        step();
        idle();
        expect_port("sb_busy_next", 1'b0, 32'h0, 1'b1);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_00A5;
        expect_port("sb_writeback_bypass", 1'b0, 32'h0000_00A5, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        step();
        idle(); shadow[7] = 32'h0000_00A5;
        expect_port("sb_cleared", 1'b0, 32'h0000_00A5, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
    endtask

    task automatic test_collision();
        idle();
        issue_en = 1'b1; issue_addr = 5'd9;
        step();
        rd_addr_a = 5'd9; rd_addr_b = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        expect_port("coll_same_cycle", 1'b0, 32'h55, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        step();
        idle(); shadow[9] = 32'h55;
        expect_port("coll_set_wins_a", 1'b0, 32'h55, 1'b1);
        expect_port("coll_set_wins_b", 1'b1, 32'h55, 1'b1);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        // Retire the outstanding producer so later tests start clean.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        step();
        idle();
    endtask

    task automatic test_dual_port();
        idle();
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h11;
        step();
        wr_addr = 5'd2; wr_data = 32'h22;
        step();
        shadow[1] = 32'h11; shadow[2] = 32'h22;
        rd_addr_a = 5'd1; rd_addr_b = 5'd2;
        wr_addr = 5'd2; wr_data = 32'h33;
        expect_port("dual_a_storage", 1'b0, 32'h11, 1'b0);
        expect_port("dual_b_bypass", 1'b1, 32'h33, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
        step();
        idle(); shadow[2] = 32'h33;
        expect_port("dual_b_stored", 1'b1, 32'h33, 1'b0);
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front(); tests_run++;
            obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
            if (obs !== {e.busy, e.data}) begin
                tests_failed++;
                $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                         e.name, obs[32], obs[31:0], e.busy, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addr;
        logic [31:0] data;
        idle();
        for (int i = 0; i < 8; i++) begin
            addr = 5'(10 + i);
            data = $urandom;
            wr_en = 1'b1; wr_addr = addr; wr_data = data;
            rd_addr_a = addr;
            rd_addr_b = 5'(addr - 5'd1);
            expect_port($sformatf("b2b_bypass_r%0d", addr), 1'b0, data, 1'b0);
            expect_port($sformatf("b2b_prev_r%0d", addr - 5'd1), 1'b1,
                        shadow[addr - 5'd1], 1'b0);
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front(); tests_run++;
                obs = e.port_b ? {rd_busy_b, rd_data_b} : {rd_busy_a, rd_data_a};
                if (obs !== {e.busy, e.data}) begin
                    tests_failed++;
                    $display("FAIL %s: got busy=%0b data=%h, want busy=%0b data=%h",
                             e.name, obs[32], obs[31:0], e.busy, e.data);
                end
            end
            shadow[addr] = data;
            step();
        end
        idle();
    endtask

    initial begin
        reset = 1'b0; idle();
        rd_addr_a = '0; rd_addr_b = '0; issue_addr = '0;
        wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
        test_reset();
        test_bypass();
        test_r0();
        test_scoreboard();
        test_collision();
        test_dual_port();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_reg_file
